// File: rtl/carcontrol_nios2_div_cell.sv
// carcontrol_nios2_div_cell: multi-cycle radix-2 restoring divider for div/divu.
// Sequence: IDLE -> PREP -> ITER (DATA_W cycles) -> FIX -> DONE.
// Optional macro CARCONTROL_NIOS2_DIV_REMAINDER_EN adds the registered,
// sign-corrected remainder output. When it is undefined, the remainder output is tied to 0.
module carcontrol_nios2_div_cell #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] M_div_src1,
    input  logic [DATA_W-1:0] M_div_src2,
    input  logic              M_div_signed,
    input  logic              M_div_start,
    output logic              M_div_busy,
    output logic              M_div_done,
    output logic [DATA_W-1:0] M_div_cell_result,
    output logic [DATA_W-1:0] M_div_cell_remainder,
    output logic              M_div_by_zero
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;
    logic              signed_q;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dvs;
    logic              q_neg;
    logic              div_zero;
    logic [CNT_W-1:0]  counter;
    logic [DATA_W-1:0] result_q;
    logic              by_zero_q;

    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;

    // Operand magnitudes. The most-negative value negates to itself, which is the correct unsigned magnitude.
    assign a_neg = signed_q & src1_q[DATA_W-1];
    assign b_neg = signed_q & src2_q[DATA_W-1];
    assign a_mag = a_neg ? (~src1_q + 1'b1) : src1_q;
    assign b_mag = b_neg ? (~src2_q + 1'b1) : src2_q;

    // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
    assign shifted = {rem, quo[DATA_W-1]};
    assign trial   = shifted - {1'b0, dvs};

    assign M_div_busy        = (state != IDLE);
    assign M_div_done        = (state == DONE);
    assign M_div_cell_result = result_q;
    assign M_div_by_zero     = by_zero_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: the iteration counter decides when ITER ends
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (M_div_start) state_next = PREP;
            PREP:    state_next = ITER;
            ITER:    if (counter == '0) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture, magnitude prep, restoring iterations and final quotient fix-up
    always_ff @(posedge clk) begin
        if (reset) begin
            src1_q    <= '0;
            src2_q    <= '0;
            signed_q  <= 1'b0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            q_neg     <= 1'b0;
            div_zero  <= 1'b0;
            counter   <= '0;
            result_q  <= '0;
            by_zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (M_div_start) begin
                        src1_q   <= M_div_src1;
                        src2_q   <= M_div_src2;
                        signed_q <= M_div_signed;
                    end
                end
                PREP: begin
                    quo      <= a_mag;
                    dvs      <= b_mag;
                    rem      <= '0;
                    q_neg    <= a_neg ^ b_neg;
                    div_zero <= (src2_q == '0);
                    counter  <= CNT_W'(DATA_W - 1);
                end
                ITER: begin
                    if (!trial[DATA_W]) rem <= trial[DATA_W-1:0];
                    else                rem <= shifted[DATA_W-1:0];
                    quo     <= {quo[DATA_W-2:0], ~trial[DATA_W]};
                    counter <= counter - 1'b1;
                end
                FIX: begin
                    by_zero_q <= div_zero;
                    if (div_zero)   result_q <= '1;
                    else if (q_neg) result_q <= ~quo + 1'b1;
                    else            result_q <= quo;
                end
                default: ;
            endcase
        end
    end

`ifdef CARCONTROL_NIOS2_DIV_REMAINDER_EN
    logic              r_neg;
    logic [DATA_W-1:0] remainder_q;

    assign M_div_cell_remainder = remainder_q;

    // Remainder takes the dividend's sign; a zero divisor returns the captured dividend
    always_ff @(posedge clk) begin
        if (reset) begin
            r_neg       <= 1'b0;
            remainder_q <= '0;
        end else begin
            if (state == PREP) r_neg <= a_neg;
            if (state == FIX) begin
                if (div_zero)   remainder_q <= src1_q;
                else if (r_neg) remainder_q <= ~rem + 1'b1;
                else            remainder_q <= rem;
            end
        end
    end
`else
    assign M_div_cell_remainder = '0;
`endif

endmodule
